// File: rtl/ika9958_clkgen.sv
// Clock-enable generator: NCH divided clocks from the master crystal clock, each with
// its own period and high time, optionally phase-locked to an external sync input.
module ika9958_clkgen #(
   parameter int NCH         = 3,
   parameter int CW          = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_XTAL1,
   input  logic              i_RST,
   input  logic              i_XTAL_CEN,
   input  logic [NCH*CW-1:0] i_DIV,
   input  logic [NCH*CW-1:0] i_HIGH,
   input  logic [NCH-1:0]    i_SYNCEN,
   input  logic              i_SYNC_n,
   output logic [NCH-1:0]    o_CLK,
   output logic [NCH-1:0]    o_PCEN,
   output logic [NCH-1:0]    o_NCEN,
   output logic              o_SYNCED
);

   logic [NCH-1:0][CW-1:0] cnt, div_s, high_s;
   logic [NCH-1:0][CW-1:0] cnt_nx, div_nx, high_nx;
   logic [NCH-1:0]         clk_nx;
   logic                   load_pend;
   logic                   sync_pend, sync_pend_nx;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_prev;
   logic                   sync_fall;

   // Synchroniser runs on every master edge so a sync fall is never missed while gated.
   always_ff @(posedge i_XTAL1 or posedge i_RST) begin
      if (i_RST) begin
         sync_chain <= '1;
         sync_prev  <= 1'b1;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], i_SYNC_n};
         sync_prev  <= sync_chain[SYNC_STAGES-1];
      end
   end

   assign sync_fall    = sync_prev & ~sync_chain[SYNC_STAGES-1];
   assign sync_pend_nx = sync_fall | (sync_pend & ~i_XTAL_CEN);

   // A boundary (first cycle after reset, applied sync, or wrap) reloads the shadows.
   always_comb begin
      cnt_nx  = cnt;
      div_nx  = div_s;
      high_nx = high_s;
      clk_nx  = o_CLK;
      for (int k = 0; k < NCH; k++) begin
         if (i_XTAL_CEN) begin
            if (load_pend || (sync_pend && i_SYNCEN[k]) || (cnt[k] == div_s[k])) begin
               cnt_nx[k]  = '0;
               div_nx[k]  = i_DIV[k*CW +: CW];
               high_nx[k] = i_HIGH[k*CW +: CW];
            end else begin
               cnt_nx[k] = cnt[k] + CW'(1);
            end
            clk_nx[k] = (cnt_nx[k] < high_nx[k]);
         end
      end
   end

   // Edge enables are gated by reset so they drop the moment reset is asserted.
   assign o_PCEN = {NCH{i_XTAL_CEN & ~i_RST}} & ~o_CLK &  clk_nx;
   assign o_NCEN = {NCH{i_XTAL_CEN & ~i_RST}} &  o_CLK & ~clk_nx;

   always_ff @(posedge i_XTAL1 or posedge i_RST) begin
      if (i_RST) begin
         cnt       <= '0;
         div_s     <= '0;
         high_s    <= '0;
         o_CLK     <= '0;
         load_pend <= 1'b1;
         sync_pend <= 1'b0;
         o_SYNCED  <= 1'b0;
      end else begin
         cnt       <= cnt_nx;
         div_s     <= div_nx;
         high_s    <= high_nx;
         o_CLK     <= clk_nx;
         sync_pend <= sync_pend_nx;
         o_SYNCED  <= i_XTAL_CEN & sync_pend;
         if (i_XTAL_CEN)
            load_pend <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ika9958_clkgen.sv
// Randomised self-checking bench for ika9958_clkgen, compared cycle by cycle
// against a period/phase reference model of each channel.
module tb_ika9958_clkgen;

   localparam int NCH = 3;
   localparam int CW  = 4;
   localparam int SS  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              cen;
   logic [NCH*CW-1:0] div;
   logic [NCH*CW-1:0] high;
   logic [NCH-1:0]    syncen;
   logic              sync_n;
   logic [NCH-1:0]    o_clk, o_pcen, o_ncen;
   logic              o_synced;

   int testCount = 0;
   int failCount = 0;

   // Reference model: position inside the current period, period length, high length.
   int             m_pos[NCH], m_per[NCH], m_hi[NCH];
   int             n_pos[NCH], n_per[NCH], n_hi[NCH];
   logic [NCH-1:0] m_clk, n_clk, exp_pcen, exp_ncen;
   logic           m_first, n_first, m_pend, n_pend, m_synced, n_synced;
   bit             sq[$];

   ika9958_clkgen #(.NCH(NCH), .CW(CW), .SYNC_STAGES(SS)) dut (
      .i_XTAL1(clk), .i_RST(rst), .i_XTAL_CEN(cen), .i_DIV(div), .i_HIGH(high),
      .i_SYNCEN(syncen), .i_SYNC_n(sync_n), .o_CLK(o_clk), .o_PCEN(o_pcen),
      .o_NCEN(o_ncen), .o_SYNCED(o_synced)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < NCH; k++) begin
         m_pos[k] = 0;
         m_per[k] = 1;
         m_hi[k]  = 0;
      end
      m_clk    = '0;
      m_first  = 1'b1;
      m_pend   = 1'b0;
      m_synced = 1'b0;
      sq.delete();
      repeat (SS + 1) sq.push_back(1'b1);
   endtask

   // Prediction of the state after the coming edge, from the current inputs.
   task automatic modelPredict();
      bit fall;
      bit bnd;
      fall   = sq[0] && !sq[1];
      n_pend = fall || (m_pend && !cen);
      for (int k = 0; k < NCH; k++) begin
         n_pos[k] = m_pos[k];
         n_per[k] = m_per[k];
         n_hi[k]  = m_hi[k];
         n_clk[k] = m_clk[k];
         if (cen) begin
            bnd = m_first || (m_pend && syncen[k]) || (m_pos[k] == m_per[k] - 1);
            if (bnd) begin
               n_pos[k] = 0;
               n_per[k] = int'(div[k*CW +: CW]) + 1;
               n_hi[k]  = int'(high[k*CW +: CW]);
            end else begin
               n_pos[k] = m_pos[k] + 1;
            end
            n_clk[k] = (n_pos[k] < n_hi[k]);
         end
      end
      n_first  = cen ? 1'b0 : m_first;
      n_synced = cen && m_pend;
      exp_pcen = cen ? (~m_clk & n_clk) : '0;
      exp_ncen = cen ? (m_clk & ~n_clk) : '0;
   endtask

   task automatic modelCommit();
      for (int k = 0; k < NCH; k++) begin
         m_pos[k] = n_pos[k];
         m_per[k] = n_per[k];
         m_hi[k]  = n_hi[k];
      end
      m_clk    = n_clk;
      m_first  = n_first;
      m_pend   = n_pend;
      m_synced = n_synced;
      sq.push_back(bit'(sync_n));
      void'(sq.pop_front());
   endtask

   // One master cycle: check at the falling edge, advance the model at the rising edge.
   task automatic applyStimulus();
      @(negedge clk);
      if (rst) begin
         checkOutput("rstClk", o_clk, 0);
         checkOutput("rstPcen", o_pcen, 0);
         checkOutput("rstNcen", o_ncen, 0);
         checkOutput("rstSynced", o_synced, 0);
      end else begin
         modelPredict();
         checkOutput("clk", o_clk, m_clk);
         checkOutput("synced", o_synced, m_synced);
         checkOutput("pcen", o_pcen, exp_pcen);
         checkOutput("ncen", o_ncen, exp_ncen);
      end
      @(posedge clk);
      if (rst) modelReset();
      else     modelCommit();
      #1;
   endtask

   task automatic setAll(input int d, input int h);
      for (int k = 0; k < NCH; k++) begin
         div[k*CW +: CW]  = CW'(d);
         high[k*CW +: CW] = CW'(h);
      end
   endtask

   initial begin
      int pulses;
      rst    = 1'b1;
      cen    = 1'b1;
      syncen = '0;
      sync_n = 1'b1;
      setAll(3, 2);
      modelReset();
      #2;
      checkOutput("asyncRstClk", o_clk, 0);
      repeat (3) applyStimulus();

      // Basic divider, then gated master clock
      rst = 1'b0;
      repeat (16) applyStimulus();
      for (int i = 0; i < 32; i++) begin
         cen = (i % 2 == 0);
         applyStimulus();
      end
      cen = 1'b1;

      // Ratio change mid-period
      repeat (5) applyStimulus();
      setAll(5, 3);
      repeat (20) applyStimulus();

      // External sync with one locked and one free channel, plus merged double fall
      syncen = 3'b001;
      setAll(7, 4);
      repeat (19) applyStimulus();
      sync_n = 1'b0;
      repeat (8) applyStimulus();
      sync_n = 1'b1;
      repeat (4) applyStimulus();
      cen = 1'b0;
      pulses = 0;
      sync_n = 1'b0;
      repeat (3) applyStimulus();
      sync_n = 1'b1;
      repeat (3) applyStimulus();
      sync_n = 1'b0;
      repeat (3) applyStimulus();
      sync_n = 1'b1;
      repeat (4) applyStimulus();
      cen = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         if (o_synced) pulses++;
      end
      checkOutput("mergedSyncPulses", pulses, 1);

      // Degenerate settings: constant low, constant high, period 1
      div[0 +: CW] = 4'd5;  high[0 +: CW] = 4'd0;
      div[CW +: CW] = 4'd7; high[CW +: CW] = 4'd9;
      div[2*CW +: CW] = 4'd0; high[2*CW +: CW] = 4'd3;
      repeat (24) applyStimulus();
      checkOutput("degenLevels", o_clk, 3'b110);

      // Randomised run
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) begin
            int k;
            k = $urandom_range(NCH - 1);
            div[k*CW +: CW]  = CW'($urandom);
            high[k*CW +: CW] = CW'($urandom);
         end
         if ($urandom_range(49) == 0) syncen = NCH'($urandom);
         if ($urandom_range(5) == 0) sync_n = ~sync_n;
         cen = ($urandom_range(3) != 0);
         applyStimulus();
      end

      // Async reset in the middle of a high phase
      cen    = 1'b1;
      sync_n = 1'b1;
      setAll(7, 4);
      begin
         int n;
         n = 0;
         while (!o_clk[0] && n < 20) begin
            applyStimulus();
            n++;
         end
      end
      checkOutput("waitHigh", o_clk[0], 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstClk", o_clk, 0);
      checkOutput("midRstPcen", o_pcen, 0);
      checkOutput("midRstNcen", o_ncen, 0);
      modelReset();
      @(posedge clk);
      #1;
      repeat (2) applyStimulus();
      rst = 1'b0;
      setAll(5, 2);
      repeat (20) applyStimulus();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
